// File: rtl/muldiv_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU. Produces one quotient bit per cycle
// and returns {HI=remainder, LO=quotient} as a single 64-bit HILO write value.
module muldiv_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               div_cancel,
  output logic               stallreq_div,
  output logic               div_done,
  output logic [2*WIDTH-1:0] div_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0]   dvd_abs, dvs_abs;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   rem_step, quot_step;

  // One restoring step: the partial remainder can reach 2*|divisor|, hence WIDTH+1 bits.
  always_comb begin
    dvd_abs = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    rem_sh  = {rem_q, quot_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvsr_q};
    if (!diff[WIDTH]) begin
      rem_step  = diff[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = rem_sh[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (div_start && !div_cancel) begin
          q_neg_d = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d = div_signed & dividend[WIDTH-1];
          dvsr_d  = dvs_abs;
          cnt_d   = '0;
          if (divisor == '0) begin
            // Divide by zero skips iteration: all-ones quotient, raw dividend as remainder.
            res_d   = {dividend, {WIDTH{1'b1}}};
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quot_d  = dvd_abs;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = rem_step;
        quot_d = quot_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d   = {r_neg_q ? -rem_step : rem_step, q_neg_q ? -quot_step : quot_step};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (div_cancel) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // NOTE: datapath registers are left unreset; they are always loaded in IDLE before being consumed.
  always_ff @(posedge clk) begin
    rem_q   <= rem_d;
    quot_q  <= quot_d;
    dvsr_q  <= dvsr_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
  end

  assign stallreq_div = ((state_q == IDLE) && div_start && !div_cancel) || (state_q == CALC);
  assign div_done     = (state_q == DONE);
  assign div_res      = res_q;

endmodule

// File: tb/tb_muldiv_div_unit.sv
// Directed self-checking bench for muldiv_div_unit: latency, signed fixups, divide by zero,
// cancel/reset aborts and back-to-back operation.
module tb_muldiv_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_cancel;
  logic        stallreq_div;
  logic        div_done;
  logic [63:0] div_res;

  int checks = 0;
  int errors = 0;

  muldiv_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .div_cancel   (div_cancel),
    .stallreq_div (stallreq_div),
    .div_done     (div_done),
    .div_res      (div_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one divide at a negedge, then scramble the operands so any re-sampling shows up.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int n;
    int stall_low;
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    #1;
    check({tag, " stall_at_start"}, 64'(stallreq_div), 64'd1);
    @(negedge clk);
    div_start = 1'b0;
    dividend  = ~a;
    divisor   = b + 32'd3;
    n         = 1;
    stall_low = 0;
    while (!div_done && n < 60) begin
      if (!stallreq_div) stall_low++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " stall_low_while_busy"}, 64'(stall_low), 64'd0);
    check({tag, " result"}, div_res, exp_res);
    check({tag, " stall_in_done"}, 64'(stallreq_div), 64'd0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(div_done), 64'd0);
    check({tag, " result_held"}, div_res, exp_res);
  endtask

  initial begin
    int dones;
    int first_at;
    int second_at;

    reset      = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    div_cancel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset div_done", 64'(div_done), 64'd0);
    check("reset stall", 64'(stallreq_div), 64'd0);
    check("reset div_res", div_res, 64'd0);
    reset = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div("div_minint_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
    run_div("divu_minint_ff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'h0});
    run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'd14});
    run_div("divu_by_zero", 1'b0, 32'h0000_1234, 32'd0, 1, {32'h0000_1234, 32'hFFFF_FFFF});

    // Cancel and start together in IDLE: nothing latched, so no zero-divisor done pulse follows.
    @(negedge clk);
    div_start  = 1'b1;
    div_cancel = 1'b1;
    dividend   = 32'h55;
    divisor    = 32'd0;
    #1;
    check("start_cancel stall", 64'(stallreq_div), 64'd0);
    @(negedge clk);
    div_start  = 1'b0;
    div_cancel = 1'b0;
    check("start_cancel no_done", 64'(div_done), 64'd0);
    check("start_cancel res", div_res, {32'h0000_1234, 32'hFFFF_FFFF});

    // Cancel during CALC at T+10.
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    div_cancel = 1'b1;
    #1;
    check("cancel stall_before", 64'(stallreq_div), 64'd1);
    @(negedge clk);
    div_cancel = 1'b0;
    #1;
    check("cancel idle_stall", 64'(stallreq_div), 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) dones++;
    end
    check("cancel no_done", 64'(dones), 64'd0);
    check("cancel res_kept", div_res, {32'h0000_1234, 32'hFFFF_FFFF});

    // Reset during CALC at T+10: returns to IDLE and clears div_res.
    @(negedge clk);
    div_start = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_mid stall", 64'(stallreq_div), 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) dones++;
    end
    check("reset_mid no_done", 64'(dones), 64'd0);
    check("reset_mid res", div_res, 64'd0);

    // Back-to-back with start held through DONE: 1000/10 twice.
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd10;
    dones      = 0;
    first_at   = 0;
    second_at  = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (div_done) begin
        dones++;
        if (dones == 1) first_at = c;
        if (dones == 2) begin
          second_at = c;
          div_start = 1'b0;
        end
      end
    end
    div_start = 1'b0;
    check("b2b pulses", 64'(dones), 64'd2);
    check("b2b first_latency", 64'(first_at), 64'd33);
    check("b2b gap", 64'(second_at - first_at), 64'd34);
    check("b2b result", div_res, {32'd0, 32'd100});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
